// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin read arbiter from sram-like ports onto one AXI3 AR/R pair
module axi_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_W        = 4,
  parameter int MAX_OUT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [2*NUM_MASTERS-1:0] m_size,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  output logic [NUM_MASTERS-1:0]   m_addr_ok,
  output logic [NUM_MASTERS-1:0]   m_data_ok,
  output logic [31:0]              m_rdata,
  output logic [ID_W-1:0]          arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, AR_WAIT} state_t;

  state_t                  state;
  logic [IW-1:0]           last_grant;
  logic [2:0]              cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  ar_inc;
  logic [NUM_MASTERS-1:0]  r_hit;
  logic [NUM_MASTERS-1:0]  r_dec;
  logic                    grant_found;
  logic [IW-1:0]           grant_idx;
  logic                    ar_fire;
  logic                    r_fire;
  logic                    unused;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = 1'b1;
  assign unused  = ^rresp;

  assign ar_fire   = arvalid && arready;
  assign r_fire    = rvalid && rlast;
  assign m_addr_ok = ar_inc;

  always_comb begin
    eligible = '0;
    ar_inc   = '0;
    r_hit    = '0;
    r_dec    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = m_req[i] && (cnt[i] < 3'(MAX_OUT));
      ar_inc[i]   = ar_fire && (last_grant == IW'(i));
      // ids outside the master range match no i, so stray beats fall through here
      r_hit[i]    = r_fire && (rid == ID_W'(i));
      r_dec[i]    = r_hit[i] && (cnt[i] != 3'd0);
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!grant_found && eligible[(int'(last_grant) + k) % NUM_MASTERS]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((int'(last_grant) + k) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      arid       <= '0;
      araddr     <= '0;
      arsize     <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            arvalid    <= 1'b1;
            arid       <= ID_W'(grant_idx);
            araddr     <= m_addr[int'(grant_idx)*32 +: 32];
            arsize     <= {1'b0, m_size[int'(grant_idx)*2 +: 2]};
            last_grant <= grant_idx;
            state      <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue and return can hit the same counter in one cycle; they cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_ok <= '0;
      m_rdata   <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) cnt[i] <= 3'd0;
    end else begin
      m_data_ok <= r_hit;
      if (|r_hit) m_rdata <= rdata;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (ar_inc[i] && !r_dec[i]) cnt[i] <= cnt[i] + 3'd1;
        else if (r_dec[i] && !ar_inc[i]) cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - vector table plus scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m_req;
  logic [3:0]  m_size;
  logic [63:0] m_addr;
  logic [1:0]  m_addr_ok;
  logic [1:0]  m_data_ok;
  logic [31:0] m_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_rd_arbiter #(.NUM_MASTERS(2), .ID_W(4), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_size(m_size), .m_addr(m_addr),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_t;
  typedef struct { logic [1:0] m; logic [31:0] d; } r_t;
  typedef struct {
    logic [1:0] req; logic [1:0] size0; logic [1:0] size1;
    logic [31:0] addr0; logic [31:0] addr1; logic [31:0] rd; int exp_id;
  } vec_t;

  ar_t exp_ar [$];
  r_t  exp_r  [$];
  int  total = 0;
  int  bad = 0;
  int  ar_pulses = 0;
  int  dok_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] a, input logic [1:0] s);
    ar_t e;
    e.id = id; e.addr = a; e.size = {1'b0, s};
    exp_ar.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] m, input logic [31:0] d);
    r_t e;
    e.m = m; e.d = d;
    exp_r.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; m_req = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b1;
    next(); next();
    reset = 1'b0;
  endtask

  // Scoreboard: every pulse consumes one expected record in order.
  always @(negedge clk) begin
    if (|m_addr_ok) begin
      ar_pulses++;
      if (exp_ar.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_ar_unexpected actual=%0b required=none", m_addr_ok);
      end else begin
        ar_t e;
        e = exp_ar.pop_front();
        check("sb_arid", arid, e.id);
        check("sb_araddr", araddr, e.addr);
        check("sb_arsize", arsize, e.size);
        check("sb_addr_ok", m_addr_ok, 64'(2'b01 << e.id));
      end
    end
    if (|m_data_ok) begin
      dok_pulses++;
      if (exp_r.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_r_unexpected actual=%0b required=none", m_data_ok);
      end else begin
        r_t e;
        e = exp_r.pop_front();
        check("sb_data_ok", m_data_ok, 64'(2'b01 << e.m));
        check("sb_rdata", m_rdata, e.d);
      end
    end
  end

  vec_t tbl [8];
  logic got;
  int   base;

  initial begin
    m_size = '0; m_addr = '0; rid = '0; rdata = '0; rresp = 2'b00;
    // last_grant starts at 1, so grants below follow from the request masks alone
    tbl[0] = '{2'b01, 2'd2, 2'd0, 32'h0000_1000, 32'h0000_2000, 32'hA000_0000, 0};
    tbl[1] = '{2'b11, 2'd2, 2'd1, 32'h0000_1100, 32'h0000_2100, 32'hA000_0001, 1};
    tbl[2] = '{2'b11, 2'd0, 2'd2, 32'h0000_1203, 32'h0000_2200, 32'hA000_0002, 0};
    tbl[3] = '{2'b10, 2'd2, 2'd1, 32'h0000_1300, 32'h0000_2302, 32'hA000_0003, 1};
    tbl[4] = '{2'b11, 2'd0, 2'd2, 32'h0000_0003, 32'h0000_2400, 32'hA000_0004, 0};
    tbl[5] = '{2'b01, 2'd1, 2'd2, 32'h0000_1502, 32'h0000_2500, 32'hA000_0005, 0};
    tbl[6] = '{2'b10, 2'd2, 2'd0, 32'h0000_1600, 32'h0000_2601, 32'hA000_0006, 1};
    tbl[7] = '{2'b11, 2'd2, 2'd2, 32'hFFFF_FFFC, 32'h0000_2700, 32'hA000_0007, 0};

    reset = 1'b1; m_req = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b1;
    next(); next();
    @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_arid", arid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arsize", arsize, 0);
    check("rst_addr_ok", m_addr_ok, 0);
    check("rst_data_ok", m_data_ok, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_rready", rready, 1);
    check("const_arlen", arlen, 0);
    check("const_arburst", arburst, 2'b01);
    check("const_misc", {arlock, arcache, arprot}, 0);
    next();

    // single read with exact latencies
    reset = 1'b0;
    m_req = 2'b01; m_addr[31:0] = 32'h1000; m_size[1:0] = 2'd2; arready = 1'b1;
    push_ar(4'd0, 32'h1000, 2'd2);
    @(negedge clk);
    check("single_c0_arvalid", arvalid, 0);
    next();
    @(negedge clk);
    check("single_c1_arvalid", arvalid, 1);
    check("single_c1_addr_ok", m_addr_ok, 2'b01);
    next();
    m_req = 2'b00;
    @(negedge clk);
    check("single_c2_arvalid", arvalid, 0);
    next(); next();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEADBEEF;
    push_r(2'd0, 32'hDEADBEEF);
    next();
    rvalid = 1'b0;
    @(negedge clk);
    check("single_c5_data_ok", m_data_ok, 2'b01);
    check("single_c5_rdata", m_rdata, 32'hDEADBEEF);
    next();
    @(negedge clk);
    check("single_c6_data_ok", m_data_ok, 2'b00);
    check("single_c6_rdata_hold", m_rdata, 32'hDEADBEEF);
    next();

    // vector table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      m_req = tbl[v].req;
      m_addr = {tbl[v].addr1, tbl[v].addr0};
      m_size = {tbl[v].size1, tbl[v].size0};
      arready = 1'b1;
      if (tbl[v].exp_id == 0) push_ar(4'd0, tbl[v].addr0, tbl[v].size0);
      else push_ar(4'd1, tbl[v].addr1, tbl[v].size1);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = |m_addr_ok;
        next();
      end
      check("tbl_grant_seen", got, 1);
      m_req = 2'b00;
      rvalid = 1'b1; rid = 4'(tbl[v].exp_id); rdata = tbl[v].rd;
      push_r(2'(tbl[v].exp_id), tbl[v].rd);
      next();
      rvalid = 1'b0;
      next(); next();
    end

    // round-robin with both masters requesting: 0,1,0,1 then the limit stops it
    do_reset();
    ar_pulses = 0;
    m_req = 2'b11; m_addr = {32'h0000_B000, 32'h0000_A000}; m_size = 4'b1010; arready = 1'b1;
    push_ar(4'd0, 32'hA000, 2'd2); push_ar(4'd1, 32'hB000, 2'd2);
    push_ar(4'd0, 32'hA000, 2'd2); push_ar(4'd1, 32'hB000, 2'd2);
    for (int c = 0; c < 14; c++) next();
    check("rr_pulses", ar_pulses, 4);
    m_req = 2'b00;

    // outstanding limit
    do_reset();
    ar_pulses = 0;
    m_req = 2'b01; m_addr[31:0] = 32'h5000; m_size[1:0] = 2'd2; arready = 1'b1;
    push_ar(4'd0, 32'h5000, 2'd2); push_ar(4'd0, 32'h5000, 2'd2);
    for (int c = 0; c < 10; c++) next();
    check("limit_two", ar_pulses, 2);
    push_ar(4'd0, 32'h5000, 2'd2);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE0001;
    push_r(2'd0, 32'hCAFE0001);
    next();
    rvalid = 1'b0;
    for (int c = 0; c < 10; c++) next();
    check("limit_one_more", ar_pulses, 3);
    m_req = 2'b00;

    // backpressure
    do_reset();
    ar_pulses = 0;
    m_req = 2'b10; m_addr[63:32] = 32'hABC0; m_size[3:2] = 2'd1; arready = 1'b0;
    push_ar(4'd1, 32'hABC0, 2'd1);
    next();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_arvalid", arvalid, 1);
      check("bp_arid", arid, 1);
      check("bp_araddr", araddr, 32'hABC0);
      check("bp_arsize", arsize, 3'b001);
      check("bp_no_addr_ok", m_addr_ok, 0);
      next();
    end
    arready = 1'b1;
    @(negedge clk);
    check("bp_release_addr_ok", m_addr_ok, 2'b10);
    next();
    m_req = 2'b00;
    next(); next(); next();
    check("bp_pulses", ar_pulses, 1);

    // simultaneous AR and R on master 1, then a stray id
    do_reset();
    ar_pulses = 0;
    m_req = 2'b10; m_addr[63:32] = 32'h2000; m_size[3:2] = 2'd2; arready = 1'b1;
    push_ar(4'd1, 32'h2000, 2'd2);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = |m_addr_ok;
      next();
    end
    check("sim_first_grant", got, 1);
    m_req = 2'b10; m_addr[63:32] = 32'h2004; arready = 1'b0;
    push_ar(4'd1, 32'h2004, 2'd2);
    next(); next();
    arready = 1'b1; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222;
    push_r(2'd1, 32'h1111_2222);
    @(negedge clk);
    check("sim_both_addr_ok", m_addr_ok, 2'b10);
    next();
    rvalid = 1'b0;
    m_addr[63:32] = 32'h2008;
    push_ar(4'd1, 32'h2008, 2'd2);
    for (int c = 0; c < 12; c++) next();
    check("sim_cnt_unchanged", ar_pulses, 3);
    m_req = 2'b00;
    base = dok_pulses;
    rvalid = 1'b1; rid = 4'd5; rdata = 32'h5555_5555;
    next();
    rvalid = 1'b0;
    next(); next();
    check("stray_no_data_ok", dok_pulses, base);

    // reset while in AR_WAIT
    do_reset();
    ar_pulses = 0;
    m_req = 2'b01; m_addr = {32'h4000, 32'h3000}; m_size = 4'b1010; arready = 1'b1;
    push_ar(4'd0, 32'h3000, 2'd2); push_ar(4'd0, 32'h3000, 2'd2);
    for (int c = 0; c < 8; c++) next();
    check("mid_fill", ar_pulses, 2);
    m_req = 2'b10; arready = 1'b0;
    next();
    @(negedge clk);
    check("mid_in_ar_wait", arvalid, 1);
    next();
    reset = 1'b1;
    next();
    reset = 1'b0; m_req = 2'b00;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h5A5A_5A5A;
    push_r(2'd1, 32'h5A5A_5A5A);
    @(negedge clk);
    check("mid_arvalid_dropped", arvalid, 0);
    next();
    rvalid = 1'b0;
    next();
    m_req = 2'b11; m_addr = {32'h4100, 32'h3100}; arready = 1'b1;
    push_ar(4'd0, 32'h3100, 2'd2); push_ar(4'd1, 32'h4100, 2'd2);
    push_ar(4'd0, 32'h3100, 2'd2); push_ar(4'd1, 32'h4100, 2'd2);
    for (int c = 0; c < 14; c++) next();
    check("mid_counters_cleared", ar_pulses, 6);
    m_req = 2'b00;
    next(); next();

    check("sb_ar_drained", exp_ar.size(), 0);
    check("sb_r_drained", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Parametrised read-side bridge between NUM_MASTERS sram-like read ports and a single AXI3 AR/R channel pair. It arbitrates read requests round-robin and tags each AR with the master index as arid. It tracks outstanding reads per master and routes R beats back by rid. It sits in the sram-to-AXI bridge alongside the write-channel logic; write requests never reach it.

## Interface
- NUM_MASTERS, 2, number of sram-like read ports (2..8); must satisfy NUM_MASTERS <= 2^ID_W
- ID_W, 4, AXI id width
- MAX_OUT, 2, max outstanding reads per master (1..7)
- Clocking and reset: reset is synchronous, active-high; the clock is clk.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m_req  in  NUM_MASTERS  per-master read request; held with m_addr/m_size until m_addr_ok
- m_size  in  2*NUM_MASTERS  per-master size (0=byte, 1=half, 2=word)
- m_addr  in  32*NUM_MASTERS  per-master byte address
- m_addr_ok  out  NUM_MASTERS  one-cycle pulse: request accepted
- m_data_ok  out  NUM_MASTERS  one-cycle pulse: m_rdata valid for that master
- m_rdata  out  32  read data, shared by all masters, qualified by m_data_ok
- arid  out  ID_W  master index of the issued read
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, granted m_size}
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  address valid
- arready  in  1  slave ready
- rid  in  ID_W  response id
- rdata  in  32  response data
- rresp  in  2  ignored
- rlast  in  1  last beat; always 1 for arlen=0
- rvalid  in  1  response valid
- rready  out  1  constant 1

## Operation
- FSM with two states: IDLE and AR_WAIT.
- IDLE: the eligible set is the masters with m_req=1 and cnt[i] < MAX_OUT. If the set is non-empty, pick the winner by round-robin. The search starts at last_grant+1 and wraps modulo NUM_MASTERS. Latch the winner's addr, size and index into the AR registers. Set arvalid=1, store last_grant=winner, and go to AR_WAIT.
- AR_WAIT: hold arvalid and all AR fields stable until arready=1. In the handshake cycle (arvalid && arready), m_addr_ok[winner]=1 combinationally, cnt[winner] increments, and the FSM returns to IDLE with arvalid=0 in the next cycle.
- R path: on rvalid && rready && rlast with rid < NUM_MASTERS, register rdata into m_rdata. In the next cycle pulse m_data_ok[rid]. cnt[rid] decrements.
- Counters: cnt[i] is 3 bits. Increment and decrement of the same counter in the same cycle leaves it unchanged. A decrement when cnt[i]=0 is ignored, because it is a protocol error.
- A beat with rid >= NUM_MASTERS is accepted and discarded: no data_ok, no counter change.
- A master at cnt=MAX_OUT is skipped and receives no addr_ok until one of its reads returns.

## Timing
- Reset values:
  - arvalid=0, arid=0, araddr=0, arsize=0
  - m_addr_ok=0, m_data_ok=0, m_rdata=0
  - all cnt=0, state=IDLE
  - last_grant=NUM_MASTERS-1, so master 0 has first priority
- rready is 1 in every cycle, including during reset.
- Request to arvalid: 1 cycle. The request is sampled in IDLE at cycle N, and arvalid=1 at N+1.
- addr_ok occurs in the AR handshake cycle. If arready is already high, that is N+1.
- AR issue rate: at most one AR every 2 cycles.
- R handshake to m_data_ok: 1 cycle. m_rdata is stable for exactly that cycle and holds until the next beat.
- An R handshake and an AR handshake in the same cycle both update their counters independently.
- Reset mid-transaction: arvalid drops, counters clear, and the FSM returns to IDLE. Late R beats are discarded through the zero-counter rule, but still produce data_ok if the rid is valid.

## Test plan
- Single read: m_req[0]=1, addr 0x1000, size 2, arready=1.
  - arvalid at cycle 1 with arid=0, araddr=0x1000, arsize=3'b010.
  - m_addr_ok[0] at cycle 1.
  - rvalid with rid=0, rdata=0xDEADBEEF at cycle 4 gives m_data_ok[0] and m_rdata=0xDEADBEEF at cycle 5.
- Round-robin: masters 0 and 1 request continuously with arready=1. Grants alternate 0,1,0,1 with arid matching, and no master is granted twice in a row.
- Outstanding limit: MAX_OUT=2, master 0 requests, no R response. Two addr_ok pulses occur, then none. One R beat with rid=0 allows exactly one more grant.
- Backpressure: arready=0 for 5 cycles after arvalid. araddr, arid and arsize stay constant and no addr_ok is issued. arready=1 gives a single addr_ok pulse.
- Simultaneous events: an AR handshake for master 1 and an R beat for rid=1 in the same cycle leave cnt[1] unchanged. A stray rid=5 with NUM_MASTERS=2 produces no data_ok.
- Mid-flight reset: assert reset while in AR_WAIT. Next cycle arvalid=0 and all counters are 0. After release, master 0 is served first.
